// File: rtl/crossing_decision_filter.sv
// Sliding-window debounce of per-frame crossing detections with
// hysteresis, a rising-edge event and a stale flag on frame timeout.
module crossing_decision_filter #(
  parameter int IMG_WIDTH      = 320,
  parameter int IMG_HEIGHT     = 240,
  parameter int WINDOW         = 8,
  parameter int ON_COUNT       = 6,
  parameter int OFF_COUNT      = 2,
  parameter int MIN_WHITE      = 2000,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic detection_valid,
  input  logic crossing_detected,
  input  logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] white_count,
  output logic crossing_confirmed,
  output logic crossing_event,
  output logic [$clog2(WINDOW+1)-1:0] hit_count,
  output logic stale
);

  localparam int CW = $clog2(IMG_WIDTH*IMG_HEIGHT);
  localparam int HW = $clog2(WINDOW+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);

  localparam logic [CW-1:0] MIN_C = CW'(MIN_WHITE);
  localparam logic [HW-1:0] WIN_C = HW'(WINDOW);
  localparam logic [HW-1:0] ON_C  = HW'(ON_COUNT);
  localparam logic [HW-1:0] OFF_C = HW'(OFF_COUNT);
  localparam logic [TW-1:0] TMO_C = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_FILL,
    S_CLEAR,
    S_CONF,
    S_STALE
  } state_t;

  state_t state_q, state_d;

  logic [WINDOW-1:0] hist_q, hist_d;
  logic [HW-1:0] hit_q, hit_d;
  logic [HW-1:0] frames_q, frames_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic conf_q, conf_d;
  logic evt_q, evt_d;
  logic stale_q, stale_d;

  logic hit;
  logic drop;
  logic expire;
  logic [HW-1:0] upd_hit;
  logic [HW-1:0] upd_frames;

  assign hit  = crossing_detected &&
                (white_count >= MIN_C);
  assign drop = (frames_q == WIN_C) &&
                hist_q[WINDOW-1];

  assign upd_hit = hit_q
                 + {{(HW-1){1'b0}}, hit}
                 - {{(HW-1){1'b0}}, drop};

  assign upd_frames = (frames_q == WIN_C) ?
                      frames_q :
                      frames_q + HW'(1);

  // Expiry is the edge on which the idle count would reach the limit.
  assign expire = !detection_valid &&
                  (tmo_q >= TMO_C - TW'(1)) &&
                  (state_q != S_STALE);

  always_comb begin
    tmo_d = tmo_q;
    if (clear || detection_valid) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_C) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_comb begin
    hist_d   = hist_q;
    hit_d    = hit_q;
    frames_d = frames_q;
    if (clear) begin
      hist_d   = '0;
      hit_d    = '0;
      frames_d = '0;
    end else if (detection_valid) begin
      hist_d   = {hist_q[WINDOW-2:0], hit};
      hit_d    = upd_hit;
      frames_d = upd_frames;
    end else if (expire) begin
      hist_d   = '0;
      hit_d    = '0;
      frames_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_FILL;
    end else if (detection_valid) begin
      unique case (state_q)
        S_FILL: begin
          if (upd_frames == WIN_C) begin
            state_d = (upd_hit >= ON_C) ?
                      S_CONF : S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (upd_hit >= ON_C) begin
            state_d = S_CONF;
          end
        end
        S_CONF: begin
          if (upd_hit <= OFF_C) begin
            state_d = S_CLEAR;
          end
        end
        S_STALE: state_d = S_FILL;
        default: state_d = S_FILL;
      endcase
    end else if (expire) begin
      state_d = S_STALE;
    end
  end

  always_comb begin
    conf_d  = (state_d == S_CONF);
    evt_d   = conf_d && !conf_q;
    stale_d = (state_d == S_STALE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q   <= '0;
      hit_q    <= '0;
      frames_q <= '0;
      tmo_q    <= '0;
      conf_q   <= 1'b0;
      evt_q    <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      hit_q    <= hit_d;
      frames_q <= frames_d;
      tmo_q    <= tmo_d;
      conf_q   <= conf_d;
      evt_q    <= evt_d;
      stale_q  <= stale_d;
    end
  end

  assign crossing_confirmed = conf_q;
  assign crossing_event     = evt_q;
  assign hit_count          = hit_q;
  assign stale              = stale_q;

endmodule

// File: tb/tb_crossing_decision_filter.sv
// Directed scoreboard bench for crossing_decision_filter.
// Expected outputs are queued with each stimulus step.
module tb_crossing_decision_filter;

  localparam int CW = 17;
  localparam int HW = 4;

  logic clk;
  logic rst_n;
  logic clear;
  logic detection_valid;
  logic crossing_detected;
  logic [CW-1:0] white_count;
  logic crossing_confirmed;
  logic crossing_event;
  logic [HW-1:0] hit_count;
  logic stale;

  typedef struct packed {
    logic [HW-1:0] hit;
    logic conf;
    logic evt;
    logic stl;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int n_cmp;
  int n_mis;

  crossing_decision_filter #(
    .IMG_WIDTH(320),
    .IMG_HEIGHT(240),
    .WINDOW(8),
    .ON_COUNT(6),
    .OFF_COUNT(2),
    .MIN_WHITE(2000),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .detection_valid(detection_valid),
    .crossing_detected(crossing_detected),
    .white_count(white_count),
    .crossing_confirmed(crossing_confirmed),
    .crossing_event(crossing_event),
    .hit_count(hit_count),
    .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string t,
                      input int h,
                      input logic c,
                      input logic e,
                      input logic s);
    exp_t x;
    x.hit  = HW'(h);
    x.conf = c;
    x.evt  = e;
    x.stl  = s;
    exp_q.push_back(x);
    tag_q.push_back(t);
  endtask

  task automatic check();
    exp_t x;
    string t;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_mis++;
      $error("FAIL sb_empty got 0 entries want >=1");
    end
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      assert (hit_count === x.hit) else begin
        n_mis++;
        $error("FAIL %s hit_count got %0d want %0d",
               t, hit_count, x.hit);
      end
      n_cmp++;
      assert (crossing_confirmed === x.conf) else begin
        n_mis++;
        $error("FAIL %s confirmed got %b want %b",
               t, crossing_confirmed, x.conf);
      end
      n_cmp++;
      assert (crossing_event === x.evt) else begin
        n_mis++;
        $error("FAIL %s event got %b want %b",
               t, crossing_event, x.evt);
      end
      n_cmp++;
      assert (stale === x.stl) else begin
        n_mis++;
        $error("FAIL %s stale got %b want %b",
               t, stale, x.stl);
      end
    end
  endtask

  // One clock of stimulus; expectation observed 1 ns after the edge.
  task automatic step(input string t,
                      input logic dv,
                      input logic cd,
                      input int wc,
                      input logic clr,
                      input int h,
                      input logic c,
                      input logic e,
                      input logic s);
    push(t, h, c, e, s);
    detection_valid   = dv;
    crossing_detected = cd;
    white_count       = CW'(wc);
    clear             = clr;
    @(posedge clk);
    #1;
    detection_valid   = 1'b0;
    crossing_detected = 1'b0;
    white_count       = '0;
    clear             = 1'b0;
    check();
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    detection_valid   = 1'b0;
    crossing_detected = 1'b0;
    white_count       = '0;

    @(posedge clk);
    #1;
    push("reset", 0, 0, 0, 0);
    check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 1; i <= 7; i++)
      step("fill", 1, 1, 5000, 0, i, 0, 0, 0);
    step("confirm", 1, 1, 5000, 0, 8, 1, 1, 0);
    step("hold", 0, 0, 0, 0, 8, 1, 0, 0);

    for (int i = 7; i >= 3; i--)
      step("hyst_down", 1, 0, 5000, 0, i, 1, 0, 0);
    step("hyst_off", 1, 0, 5000, 0, 2, 0, 0, 0);
    step("drain", 1, 0, 5000, 0, 1, 0, 0, 0);
    step("drain", 1, 0, 5000, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      step("hyst_up", 1, 1, 5000, 0, i, 0, 0, 0);
    step("hyst_on", 1, 1, 5000, 0, 6, 1, 1, 0);

    step("clear", 0, 0, 0, 1, 0, 0, 0, 0);
    step("wc_1999", 1, 1, 1999, 0, 0, 0, 0, 0);
    step("wc_2000", 1, 1, 2000, 0, 1, 0, 0, 0);
    step("det0_9000", 1, 0, 9000, 0, 1, 0, 0, 0);

    step("clear_dv", 1, 1, 5000, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++)
      step("refill", 1, 1, 5000, 0, i, 0, 0, 0);
    step("reconfirm", 1, 1, 5000, 0, 8, 1, 1, 0);

    for (int i = 1; i <= 99; i++)
      step("tmo_wait", 0, 0, 0, 0, 8, 1, 0, 0);
    step("tmo_stale", 0, 0, 0, 0, 0, 0, 0, 1);
    step("stale_exit", 1, 1, 5000, 0, 1, 0, 0, 0);
    step("after_stale", 1, 1, 5000, 0, 2, 0, 0, 0);

    for (int i = 1; i <= 99; i++)
      step("tmo_wait2", 0, 0, 0, 0, 2, 0, 0, 0);
    step("dv_at_tmo", 1, 1, 5000, 0, 3, 0, 0, 0);
    for (int i = 1; i <= 99; i++)
      step("tmo_restart", 0, 0, 0, 0, 3, 0, 0, 0);
    step("tmo_stale2", 0, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 1; i <= 7; i++)
      step("fill3", 1, 1, 5000, 0, i, 0, 0, 0);
    step("confirm3", 1, 1, 5000, 0, 8, 1, 1, 0);

    #3;
    rst_n = 1'b0;
    #1;
    push("async_rst", 0, 0, 0, 0);
    check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++)
      step("post_rst", 1, 1, 5000, 0, i, 0, 0, 0);
    step("post_rst_conf", 1, 1, 5000, 0, 8, 1, 1, 0);
    step("post_rst_hold", 0, 0, 0, 0, 8, 1, 0, 0);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_mis++;
      $error("FAIL sb_leftover got %0d want 0",
             exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
